// File: rtl/step_ctrl.sv
// Two-button step controller: synchronizes and debounces btn_up/btn_dn,
// turns a clean press into a fixed-width nxt strobe with direction on dir,
// and auto-repeats while the initiating button stays held.
module step_ctrl #(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned REP_DELAY  = 16,
  parameter int unsigned REP_PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  output logic nxt,
  output logic dir,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, WAIT} state_t;

  // Exit thresholds on the cycles-since-rise counter (0 in the first PULSE cycle).
  localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
  localparam logic [15:0] PULSE_END = 16'(PULSE_W - 1);
  localparam logic [15:0] GAP_END   = 16'(2 * PULSE_W - 1);
  localparam logic [15:0] DLY_EXIT  = 16'(REP_DELAY - 2);
  localparam logic [15:0] PER_EXIT  = 16'(REP_PERIOD - 2);

  // Index 0 = up button, index 1 = down button.
  logic [1:0]  raw;
  logic [1:0]  sync1, sync2;
  logic [1:0]  db, db_q;
  logic [15:0] db_cnt [2];

  state_t      state, state_n;
  logic        dir_n;
  logic        rep;
  logic [15:0] since_rise;
  logic        up_ev, dn_ev, hold_ok;
  logic [15:0] wait_exit;

  assign raw = {btn_dn, btn_up};

  // Two-flop synchronizers followed by a consecutive-mismatch debounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_q   <= '0;
      db_cnt <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync1[i] <= raw[i];
        sync2[i] <= sync1[i];
        db_q[i]  <= db[i];
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != '1) begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A press counts only when the other button is debounced low.
  always_comb begin
    up_ev   = db[0] & ~db_q[0] & ~db[1];
    dn_ev   = db[1] & ~db_q[1] & ~db[0];
    // dir doubles as the record of which button started the sequence.
    hold_ok = dir ? (db[1] & ~db[0]) : (db[0] & ~db[1]);
    wait_exit = rep ? PER_EXIT : DLY_EXIT;
  end

  // Next-state, direction load and Moore outputs.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    nxt     = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (up_ev) begin
          state_n = SETUP;
          dir_n   = 1'b0;
        end else if (dn_ev) begin
          state_n = SETUP;
          dir_n   = 1'b1;
        end
      end
      SETUP: state_n = PULSE;
      PULSE: begin
        nxt = 1'b1;
        if (since_rise >= PULSE_END) state_n = GAP;
      end
      GAP: begin
        if (since_rise >= GAP_END) state_n = hold_ok ? WAIT : IDLE;
      end
      WAIT: begin
        if (!hold_ok)                     state_n = IDLE;
        else if (since_rise >= wait_exit) state_n = SETUP;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, direction, repeat flag and saturating cycles-since-rise counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= 1'b0;
      rep        <= 1'b0;
      since_rise <= '0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      if (state == IDLE)                           rep <= 1'b0;
      else if (state == WAIT && state_n == SETUP)  rep <= 1'b1;
      // SETUP always precedes PULSE, so clearing here zeroes the count on the rise cycle.
      if (state == SETUP)          since_rise <= '0;
      else if (since_rise != '1)   since_rise <= since_rise + 16'd1;
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: table of button scenarios with a
// scoreboard of expected nxt rise cycles, plus hand-written reset and
// latency sequences.
module tb_step_ctrl;

  localparam int DB   = 4;
  localparam int PW   = 2;
  localparam int RDLY = 16;
  localparam int RPER = 8;
  localparam int LAT  = DB + 4;

  logic clk, rst_n, btn_up, btn_dn;
  logic nxt, dir, busy;

  step_ctrl #(
    .DB_CYCLES (DB),
    .PULSE_W   (PW),
    .REP_DELAY (RDLY),
    .REP_PERIOD(RPER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .nxt   (nxt),
    .dir   (dir),
    .busy  (busy)
  );

  typedef struct {
    int cyc;
    int dir;
  } exp_t;

  typedef struct {
    int up_on, up_len, dn_on, dn_len, bounce, n_rise, first, end_dir;
  } row_t;

  exp_t exp_q[$];
  row_t rows[8];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic nxt_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int d);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed nxt rise must match the oldest expected rise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      nxt_q <= 1'b0;
    end else begin
      if (nxt && !nxt_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rise: got rise at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rise_cycle", cyc, e.cyc);
          check("rise_dir", int'(dir), e.dir);
        end
      end
      nxt_q <= nxt;
    end
  end

  initial begin
    int P, R, T;
    logic dn_b;

    rows[0] = '{0, 10,  0,  0, 0, 1,  8, 0};  // clean up press
    rows[1] = '{0,  0,  0, 12, 0, 1,  8, 1};  // clean down press
    rows[2] = '{0, 20,  0, 20, 0, 0,  0, 1};  // both at once: no event, dir held
    rows[3] = '{0, 60,  0,  0, 0, 7,  8, 0};  // long hold: auto-repeat
    rows[4] = '{0,  0,  6, 12, 3, 1, 14, 1};  // bouncing down press
    rows[5] = '{0,  3,  0,  0, 0, 0,  0, 1};  // one cycle short of debounce
    rows[6] = '{0,  4,  0,  0, 0, 1,  8, 0};  // exactly debounce length
    rows[7] = '{0, 40, 14, 30, 0, 1,  8, 0};  // down pressed during up WAIT

    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    #3;
    check("reset_nxt",  int'(nxt),  0);
    check("reset_dir",  int'(dir),  0);
    check("reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      P = cyc;
      for (int k = 0; k < rows[r].n_rise; k++) begin
        if (k == 0) push(P + rows[r].first, rows[r].end_dir);
        else        push(P + rows[r].first + RDLY + RPER * (k - 1), rows[r].end_dir);
      end
      T = rows[r].up_on + rows[r].up_len;
      if (rows[r].dn_on + rows[r].dn_len > T) T = rows[r].dn_on + rows[r].dn_len;
      T = T + 30;
      for (int t = 0; t < T; t++) begin
        btn_up = (t >= rows[r].up_on) && (t < rows[r].up_on + rows[r].up_len);
        dn_b = (rows[r].bounce > 0) && (t >= rows[r].dn_on - 2 * rows[r].bounce) &&
               (t < rows[r].dn_on) && (((rows[r].dn_on - t) % 2) == 0);
        btn_dn = dn_b || ((t >= rows[r].dn_on) && (t < rows[r].dn_on + rows[r].dn_len));
        @(negedge clk);
      end
      check($sformatf("row%0d_missing_rises", r), exp_q.size(), 0);
      check($sformatf("row%0d_end_dir", r), int'(dir), rows[r].end_dir);
      check($sformatf("row%0d_end_busy", r), int'(busy), 0);
      exp_q.delete();
    end

    // Asynchronous reset in the middle of a down pulse, button kept held.
    @(negedge clk);
    P = cyc;
    btn_dn = 1'b1;
    push(P + LAT, 1);
    repeat (LAT) @(negedge clk);
    check("pre_reset_nxt", int'(nxt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_nxt",  int'(nxt),  0);
    check("async_rst_dir",  int'(dir),  0);
    check("async_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    R = cyc;
    push(R + LAT, 1);
    repeat (10) @(negedge clk);
    btn_dn = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_seq_missing_rises", exp_q.size(), 0);
    check("rst_seq_end_dir", int'(dir), 1);
    exp_q.delete();

    // Latency, busy onset and pulse width of a single up press.
    @(negedge clk);
    P = cyc;
    btn_up = 1'b1;
    push(P + LAT, 0);
    repeat (LAT - 2) @(negedge clk);
    check("busy_before_setup", int'(busy), 0);
    @(negedge clk);
    check("busy_in_setup", int'(busy), 1);
    check("nxt_in_setup",  int'(nxt),  0);
    check("dir_in_setup",  int'(dir),  0);
    @(negedge clk);
    check("nxt_first_cycle", int'(nxt), 1);
    @(negedge clk);
    check("nxt_second_cycle", int'(nxt), 1);
    @(negedge clk);
    check("nxt_after_width", int'(nxt), 0);
    check("busy_in_gap", int'(busy), 1);
    btn_up = 1'b0;
    repeat (30) @(negedge clk);
    check("lat_seq_missing_rises", exp_q.size(), 0);
    check("lat_seq_end_busy", int'(busy), 0);
    check("lat_seq_end_dir", int'(dir), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
